// File: rtl/d_bch_serial_encoder_pkg.sv
// BCH(8191) code constants for the serial encoder: field, strength, frame size and g(x).
// g(x) is built once at elaboration from the minimal polynomials of alpha^1, alpha^3 .. alpha^(2t-1).
package d_bch_serial_encoder_pkg;

    localparam int D_BCH_GF_ORDER    = 13;
    localparam int D_BCH_ECC_T       = 14;
    localparam int D_BCH_PARITY_BITS = D_BCH_GF_ORDER * D_BCH_ECC_T;
    localparam int D_BCH_MSG_BITS    = 4096;

    // x^13 + x^4 + x^3 + x + 1, the same field the syndrome calculator uses
    localparam logic [D_BCH_GF_ORDER:0] D_BCH_PRIM_POLY = 14'h201B;

    function automatic logic [D_BCH_GF_ORDER-1:0] gf_mul(
        input logic [D_BCH_GF_ORDER-1:0] a,
        input logic [D_BCH_GF_ORDER-1:0] b
    );
        logic [D_BCH_GF_ORDER-1:0] acc;
        logic [D_BCH_GF_ORDER-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < D_BCH_GF_ORDER; k++) begin
            if (b[k]) acc = acc ^ sh;
            if (sh[D_BCH_GF_ORDER-1]) sh = (sh << 1) ^ D_BCH_PRIM_POLY[D_BCH_GF_ORDER-1:0];
            else                      sh = sh << 1;
        end
        return acc;
    endfunction

    // 2^13-1 is prime, so every conjugacy class used here has exactly GF_ORDER members.
    function automatic logic [D_BCH_PARITY_BITS:0] calc_gen_poly();
        logic [D_BCH_PARITY_BITS:0]                     g;
        logic [D_BCH_PARITY_BITS:0]                     prod;
        logic [(D_BCH_GF_ORDER+1)*D_BCH_GF_ORDER-1:0]   mpoly;
        logic [D_BCH_GF_ORDER-1:0]                      alpha_i;
        logic [D_BCH_GF_ORDER-1:0]                      root;
        logic [D_BCH_GF_ORDER-1:0]                      c;
        g       = '0;
        g[0]    = 1'b1;
        alpha_i = D_BCH_GF_ORDER'(1);
        for (int i = 1; i < 2 * D_BCH_ECC_T; i++) begin
            alpha_i = gf_mul(alpha_i, D_BCH_GF_ORDER'(2));
            if (i % 2 == 1) begin
                mpoly = '0;
                mpoly[0 +: D_BCH_GF_ORDER] = D_BCH_GF_ORDER'(1);
                root = alpha_i;
                for (int j = 0; j < D_BCH_GF_ORDER; j++) begin
                    for (int k = D_BCH_GF_ORDER; k >= 0; k--) begin
                        c = gf_mul(root, mpoly[k*D_BCH_GF_ORDER +: D_BCH_GF_ORDER]);
                        if (k > 0) c = c ^ mpoly[(k-1)*D_BCH_GF_ORDER +: D_BCH_GF_ORDER];
                        mpoly[k*D_BCH_GF_ORDER +: D_BCH_GF_ORDER] = c;
                    end
                    root = gf_mul(root, root);
                end
                prod = '0;
                for (int k = 0; k <= D_BCH_GF_ORDER; k++) begin
                    if (mpoly[k*D_BCH_GF_ORDER]) prod = prod ^ (g << k);
                end
                g = prod;
            end
        end
        return g;
    endfunction

    localparam logic [D_BCH_PARITY_BITS:0] D_BCH_GEN_POLY = calc_gen_poly();

endpackage

// File: rtl/d_bch_serial_encoder_lfs_xor_gen.sv
// One-step serial divider: next remainder after shifting one message bit into r(x) mod g(x).
// Latency: combinational.
// Backpressure: none; the caller decides when the step is committed.
module d_bch_serial_encoder_lfs_xor_gen
    import d_bch_serial_encoder_pkg::*;
#(
    parameter int                     PARITY_BITS = D_BCH_PARITY_BITS,
    parameter logic [PARITY_BITS:0]   GEN_POLY    = D_BCH_GEN_POLY
) (
    input  logic                      i_message,
    input  logic [PARITY_BITS-1:0]    i_cur_remainder,
    output logic [PARITY_BITS-1:0]    o_nxt_remainder
);

    logic fb;

    assign fb = i_message ^ i_cur_remainder[PARITY_BITS-1];

    genvar i;
    generate
        for (i = 0; i < PARITY_BITS; i++) begin : g_tap
            if (i == 0) begin : g_lsb
                if (GEN_POLY[0]) begin : g_xor
                    assign o_nxt_remainder[0] = fb;
                end else begin : g_zero
                    assign o_nxt_remainder[0] = 1'b0;
                end
            end else begin : g_upper
                if (GEN_POLY[i]) begin : g_xor
                    assign o_nxt_remainder[i] = i_cur_remainder[i-1] ^ fb;
                end else begin : g_pass
                    assign o_nxt_remainder[i] = i_cur_remainder[i-1];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/d_bch_serial_encoder.sv
// Bit-serial systematic BCH encoder: message bits pass through, then the 182 parity bits MSB first.
// Latency: an accepted bit is on o_codeword the next cycle; 1 bit/cycle sustained.
// Backpressure: single output register; i_codeword_ready low stalls both message intake and parity shift.
module d_bch_serial_encoder
    import d_bch_serial_encoder_pkg::*;
#(
    parameter int                         GF_ORDER = D_BCH_GF_ORDER,
    parameter int                         ECC_T    = D_BCH_ECC_T,
    parameter int                         MSG_BITS = D_BCH_MSG_BITS,
    parameter logic [GF_ORDER*ECC_T:0]    GEN_POLY = D_BCH_GEN_POLY
) (
    input  logic i_clk,
    input  logic i_nRESET,
    input  logic i_message_valid,
    input  logic i_message,
    output logic o_message_ready,
    output logic o_codeword_valid,
    output logic o_codeword,
    output logic o_codeword_last,
    input  logic i_codeword_ready,
    output logic o_busy
);

    localparam int PARITY_BITS = GF_ORDER * ECC_T;
    localparam int MSG_CNT_W   = $clog2(MSG_BITS);
    localparam int PAR_CNT_W   = $clog2(PARITY_BITS);

    localparam logic [MSG_CNT_W-1:0] MSG_LAST = MSG_CNT_W'(MSG_BITS - 1);
    localparam logic [PAR_CNT_W-1:0] PAR_LAST = PAR_CNT_W'(PARITY_BITS - 1);

    localparam logic [0:0] ST_MSG    = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;

    generate
        if (MSG_BITS + PARITY_BITS > (1 << GF_ORDER) - 1) begin : g_len_check
            $error("codeword length exceeds 2^GF_ORDER-1");
        end
        if (!(GEN_POLY[PARITY_BITS] && GEN_POLY[0])) begin : g_poly_check
            $error("GEN_POLY must have its top and constant coefficients set");
        end
    endgenerate

    logic [0:0]             state_q,    state_d;
    logic [PARITY_BITS-1:0] rem_q,      rem_d;
    logic [PARITY_BITS-1:0] rem_step;
    logic [MSG_CNT_W-1:0]   msg_cnt_q,  msg_cnt_d;
    logic [PAR_CNT_W-1:0]   par_cnt_q,  par_cnt_d;
    logic                   out_v_q,    out_v_d;
    logic                   out_d_q,    out_d_d;
    logic                   out_last_q, out_last_d;

    logic can_load;
    logic msg_fire;
    logic par_load;

    d_bch_serial_encoder_lfs_xor_gen #(
        .PARITY_BITS     (PARITY_BITS),
        .GEN_POLY        (GEN_POLY)
    ) u_lfs_xor_gen (
        .i_message       (i_message),
        .i_cur_remainder (rem_q),
        .o_nxt_remainder (rem_step)
    );

    assign can_load = ~out_v_q | i_codeword_ready;
    assign msg_fire = (state_q == ST_MSG) & i_message_valid & can_load;
    assign par_load = (state_q == ST_PARITY) & can_load;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        msg_cnt_d  = msg_cnt_q;
        par_cnt_d  = par_cnt_q;
        out_v_d    = out_v_q;
        out_d_d    = out_d_q;
        out_last_d = out_last_q;
        if (msg_fire) begin
            rem_d      = rem_step;
            out_v_d    = 1'b1;
            out_d_d    = i_message;
            out_last_d = 1'b0;
            if (msg_cnt_q == MSG_LAST) begin
                msg_cnt_d = '0;
                state_d   = ST_PARITY;
            end else begin
                msg_cnt_d = msg_cnt_q + MSG_CNT_W'(1);
            end
        end else if (par_load) begin
            // remainder drains MSB first; after the last shift it is all zero again
            rem_d      = {rem_q[PARITY_BITS-2:0], 1'b0};
            out_v_d    = 1'b1;
            out_d_d    = rem_q[PARITY_BITS-1];
            out_last_d = (par_cnt_q == PAR_LAST);
            if (par_cnt_q == PAR_LAST) begin
                par_cnt_d = '0;
                state_d   = ST_MSG;
            end else begin
                par_cnt_d = par_cnt_q + PAR_CNT_W'(1);
            end
        end else if (i_codeword_ready) begin
            out_v_d    = 1'b0;
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nRESET) begin
        if (!i_nRESET) begin
            state_q    <= ST_MSG;
            rem_q      <= '0;
            msg_cnt_q  <= '0;
            par_cnt_q  <= '0;
            out_v_q    <= 1'b0;
            out_d_q    <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            msg_cnt_q  <= msg_cnt_d;
            par_cnt_q  <= par_cnt_d;
            out_v_q    <= out_v_d;
            out_d_q    <= out_d_d;
            out_last_q <= out_last_d;
        end
    end

    assign o_message_ready  = (state_q == ST_MSG) & can_load;
    assign o_codeword_valid = out_v_q;
    assign o_codeword       = out_d_q;
    assign o_codeword_last  = out_last_q;
    assign o_busy           = (state_q == ST_PARITY) | out_v_q | (msg_cnt_q != '0);

endmodule

// File: tb/tb_d_bch_serial_encoder.sv
// Bench for the serial BCH encoder: random frames against polynomial long division and GF(2^13) syndromes.
module tb_d_bch_serial_encoder;
    import d_bch_serial_encoder_pkg::*;

    localparam int P  = D_BCH_PARITY_BITS;
    localparam int MB = D_BCH_MSG_BITS;
    localparam int N  = MB + P;
    localparam int Q  = 8191;
    localparam logic [P:0] GEN = D_BCH_GEN_POLY;

    logic i_clk = 1'b0;
    logic i_nRESET;
    logic i_message_valid;
    logic i_message;
    logic o_message_ready;
    logic o_codeword_valid;
    logic o_codeword;
    logic o_codeword_last;
    logic i_codeword_ready;
    logic o_busy;

    always #5 i_clk = ~i_clk;

    d_bch_serial_encoder dut (
        .i_clk            (i_clk),
        .i_nRESET         (i_nRESET),
        .i_message_valid  (i_message_valid),
        .i_message        (i_message),
        .o_message_ready  (o_message_ready),
        .o_codeword_valid (o_codeword_valid),
        .o_codeword       (o_codeword),
        .o_codeword_last  (o_codeword_last),
        .i_codeword_ready (i_codeword_ready),
        .o_busy           (o_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [12:0] gf_exp [0:Q-1];
    bit [MB-1:0] frames [0:1];
    bit          out_q[$];
    bit          last_q[$];
    int          first_acc, first_vld, par_rdy_viol, b2b_hits;
    bit          timed_out, busy_mid, vld_after_rst, rdy_after_rst;

    function automatic bit [P-1:0] model_parity(input bit [MB-1:0] m);
        bit [N-1:0] rem;
        rem = {m, {P{1'b0}}};
        for (int d = N - 1; d >= P; d--)
            if (rem[d]) rem[d -: P+1] = rem[d -: P+1] ^ GEN;
        return rem[P-1:0];
    endfunction

    function automatic logic [12:0] syndrome(input logic [N-1:0] cw, input int i);
        logic [12:0] s;
        s = '0;
        for (int d = 0; d < N; d++)
            if (cw[d] === 1'b1) s = s ^ gf_exp[(i * d) % Q];
        return s;
    endfunction

    function automatic int nonzero_syndromes(input logic [N-1:0] cw);
        int nz;
        nz = 0;
        for (int i = 1; i < 2 * D_BCH_ECC_T; i += 2)
            if (syndrome(cw, i) != 13'd0) nz++;
        return nz;
    endfunction

    function automatic logic [N-1:0] get_cw(input int f);
        logic [N-1:0] cw;
        cw = 'x;
        for (int k = 0; k < N; k++)
            if (f * N + k < out_q.size()) cw[N-1-k] = out_q[f * N + k];
        return cw;
    endfunction

    function automatic int first_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int k = 0; k < N; k++)
            if (a[N-1-k] !== b[N-1-k]) return k;
        return -1;
    endfunction

    task automatic rand_frame(input int f);
        for (int w = 0; w < MB / 32; w++) frames[f][w*32 +: 32] = $urandom();
    endtask

    // Drives nframes back to back and records every bit the sink takes.
    task automatic run_stream(input int nframes, input int gap_pct, input int stall_pct, input int abort_at);
        int acc, smp, budget, f, t;
        acc = 0; smp = 0; budget = nframes * N * 8 + 200;
        out_q.delete(); last_q.delete();
        first_acc = -1; first_vld = -1; par_rdy_viol = 0; b2b_hits = 0; timed_out = 0; busy_mid = 0;
        while (out_q.size() < nframes * N) begin
            @(negedge i_clk);
            if (acc < nframes * MB) begin
                i_message_valid = ($urandom_range(99) >= gap_pct);
                i_message       = frames[acc / MB][MB - 1 - (acc % MB)];
            end else begin
                i_message_valid = 1'b0;
                i_message       = 1'b0;
            end
            i_codeword_ready = ($urandom_range(99) >= stall_pct);
            #1;
            f = out_q.size() / N;
            t = out_q.size() % N;
            if (acc >= (f + 1) * MB && t <= N - 2 && o_message_ready) par_rdy_viol++;
            if (out_q.size() == MB / 2) busy_mid = o_busy;
            if (i_message_valid && o_message_ready) begin
                if (first_acc < 0) first_acc = smp;
                if (o_codeword_valid && o_codeword_last) b2b_hits++;
                acc++;
            end
            if (o_codeword_valid && first_vld < 0) first_vld = smp;
            if (o_codeword_valid && i_codeword_ready) begin
                out_q.push_back(o_codeword);
                last_q.push_back(o_codeword_last);
            end
            smp++;
            if (abort_at > 0 && out_q.size() == abort_at) begin
                i_nRESET = 1'b0;
                #1;
                vld_after_rst = o_codeword_valid;
                rdy_after_rst = o_message_ready;
                return;
            end
            if (smp > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(negedge i_clk);
        i_message_valid  = 1'b0;
        i_codeword_ready = 1'b1;
    endtask

    task automatic test_reset();
        i_nRESET = 1'b0; i_message_valid = 1'b0; i_message = 1'b0; i_codeword_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        checks++; if (o_codeword_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_codeword_valid); end
        checks++; if (o_codeword !== 1'b0) begin errors++; $display("FAIL reset_codeword: got %b want 0", o_codeword); end
        checks++; if (o_codeword_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", o_codeword_last); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_message_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_message_ready); end
        @(negedge i_clk);
        i_nRESET = 1'b1;
    endtask

    task automatic test_all_zero();
        int ones, lasts, lpos;
        frames[0] = '0;
        run_stream(1, 0, 0, 0);
        ones = 0; lasts = 0; lpos = -1;
        foreach (out_q[k]) begin
            if (out_q[k]) ones++;
            if (last_q[k]) begin lasts++; lpos = k; end
        end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL zero_timeout: got %0d bits want %0d", out_q.size(), N); end
        checks++; if (out_q.size() != N) begin errors++; $display("FAIL zero_len: got %0d want %0d", out_q.size(), N); end
        checks++; if (ones != 0) begin errors++; $display("FAIL zero_ones: got %0d want 0", ones); end
        checks++; if (lasts != 1 || lpos != N - 1) begin errors++; $display("FAIL zero_last: got %0d pulses at %0d want 1 at %0d", lasts, lpos, N - 1); end
        checks++; if (first_vld - first_acc != 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", first_vld - first_acc); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL zero_busy_mid: got %b want 1", busy_mid); end
        repeat (2) @(negedge i_clk);
        #1;
        checks++; if (o_busy !== 1'b0 || o_codeword_valid !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy %b valid %b want 0 0", o_busy, o_codeword_valid); end
    endtask

    task automatic test_last_bit_one();
        logic [N-1:0] cw;
        frames[0] = '0;
        frames[0][0] = 1'b1;
        run_stream(1, 0, 0, 0);
        cw = get_cw(0);
        checks++; if (cw[P-1:0] !== GEN[P-1:0]) begin errors++; $display("FAIL lastbit_parity: got %h want %h", cw[P-1:0], GEN[P-1:0]); end
        checks++; if (cw[N-1:P] !== frames[0]) begin errors++; $display("FAIL lastbit_msg: first diff at bit %0d", first_diff(cw, {frames[0], GEN[P-1:0]})); end
    endtask

    task automatic test_random_syndrome();
        logic [N-1:0] cw, cw2, expw;
        logic [12:0]  s1;
        int           nz;
        for (int r = 0; r < 4; r++) begin
            rand_frame(0);
            run_stream(1, 0, 0, 0);
            cw   = get_cw(0);
            expw = {frames[0], model_parity(frames[0])};
            checks++; if (cw !== expw) begin errors++; $display("FAIL rand%0d_codeword: first diff at bit %0d got %b want %b", r, first_diff(cw, expw), cw[N-1-first_diff(cw, expw)], expw[N-1-first_diff(cw, expw)]); end
            nz = nonzero_syndromes(cw);
            checks++; if (nz != 0) begin errors++; $display("FAIL rand%0d_syndromes: got %0d nonzero want 0", r, nz); end
            if (r == 0) begin
                cw2 = cw;
                cw2[N-1-37] = ~cw2[N-1-37];
                s1 = syndrome(cw2, 1);
                checks++; if (s1 !== gf_exp[N-1-37]) begin errors++; $display("FAIL flip37_s1: got %h want %h", s1, gf_exp[N-1-37]); end
            end
        end
    endtask

    task automatic test_stalls();
        logic [N-1:0] cw, expw;
        int           lasts;
        rand_frame(0);
        run_stream(1, 30, 30, 0);
        cw   = get_cw(0);
        expw = {frames[0], model_parity(frames[0])};
        lasts = 0;
        foreach (last_q[k]) if (last_q[k]) lasts++;
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %0d bits want %0d", out_q.size(), N); end
        checks++; if (cw !== expw) begin errors++; $display("FAIL stall_codeword: first diff at bit %0d", first_diff(cw, expw)); end
        checks++; if (par_rdy_viol != 0) begin errors++; $display("FAIL stall_ready_in_parity: got %0d cycles want 0", par_rdy_viol); end
        checks++; if (lasts != 1 || last_q[N-1] !== 1'b1) begin errors++; $display("FAIL stall_last: got %0d pulses want 1 at end", lasts); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] cw0, cw1, exp0, exp1;
        int           nz;
        rand_frame(0);
        rand_frame(1);
        run_stream(2, 0, 0, 0);
        cw0 = get_cw(0); exp0 = {frames[0], model_parity(frames[0])};
        cw1 = get_cw(1); exp1 = {frames[1], model_parity(frames[1])};
        checks++; if (b2b_hits != 1) begin errors++; $display("FAIL b2b_accept_after_last: got %0d want 1", b2b_hits); end
        checks++; if (cw0 !== exp0) begin errors++; $display("FAIL b2b_frame0: first diff at bit %0d", first_diff(cw0, exp0)); end
        checks++; if (cw1 !== exp1) begin errors++; $display("FAIL b2b_frame1: first diff at bit %0d", first_diff(cw1, exp1)); end
        nz = nonzero_syndromes(cw1);
        checks++; if (nz != 0) begin errors++; $display("FAIL b2b_syndromes: got %0d nonzero want 0", nz); end
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] cw, expw;
        int           nz;
        rand_frame(0);
        run_stream(1, 0, 0, MB + 90);
        checks++; if (vld_after_rst !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", vld_after_rst); end
        checks++; if (rdy_after_rst !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", rdy_after_rst); end
        i_message_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_nRESET = 1'b1;
        rand_frame(0);
        run_stream(1, 0, 0, 0);
        cw   = get_cw(0);
        expw = {frames[0], model_parity(frames[0])};
        checks++; if (cw !== expw) begin errors++; $display("FAIL midrst_codeword: first diff at bit %0d", first_diff(cw, expw)); end
        nz = nonzero_syndromes(cw);
        checks++; if (nz != 0) begin errors++; $display("FAIL midrst_syndromes: got %0d nonzero want 0", nz); end
    endtask

    initial begin
        logic [13:0] v;
        v = 14'd1;
        for (int j = 0; j < Q; j++) begin
            gf_exp[j] = v[12:0];
            v = v << 1;
            if (v[13]) v = v ^ 14'h201B;
        end
        test_reset();
        test_all_zero();
        test_last_bit_one();
        test_random_syndrome();
        test_stalls();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
